// File: rtl/operand_pairer_if.sv
// operand_pairer_if
// Bundles the setpoint/measurement input strobes and the operand-pair output
// bus of operand_pairer.
//   master : drives sp_en/sp_in/sp_clr/meas_en/meas_in and observes the outputs
//            (the producer of setpoints and samples, e.g. a testbench)
//   slave  : the operand_pairer itself; receives the strobes and drives
//            data_out/extra_data_out/data_en_out/armed/drop_cnt
interface operand_pairer_if #(
  parameter int NUM_BITS  = 32,
  parameter int DROP_BITS = 8
);
  logic                 sp_en;
  logic [NUM_BITS-1:0]  sp_in;
  logic                 sp_clr;
  logic                 meas_en;
  logic [NUM_BITS-1:0]  meas_in;
  logic [NUM_BITS-1:0]  data_out;
  logic [NUM_BITS-1:0]  extra_data_out;
  logic                 data_en_out;
  logic                 armed;
  logic [DROP_BITS-1:0] drop_cnt;

  modport master (
    output sp_en, sp_in, sp_clr, meas_en, meas_in,
    input  data_out, extra_data_out, data_en_out, armed, drop_cnt
  );

  modport slave (
    input  sp_en, sp_in, sp_clr, meas_en, meas_in,
    output data_out, extra_data_out, data_en_out, armed, drop_cnt
  );
endinterface

// File: rtl/operand_pairer.sv
// operand_pairer
// Holds the most recent setpoint and pairs it with incoming measurement
// samples, producing registered single-cycle-strobed (setpoint, measurement)
// operand pairs for the downstream subtract cell, with optional decimation.
// Output is suppressed until a setpoint has been loaded.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : operand_pairer_if.slave
//            sp_en/sp_in    setpoint update strobe and value
//            sp_clr         invalidate setpoint, return to WAIT_SP
//            meas_en/meas_in measurement strobe and value
//            data_out       setpoint operand (downstream data_in)
//            extra_data_out measurement operand (downstream extra_data)
//            data_en_out    one-cycle pair-valid strobe
//            armed          1 while in RUN
//            drop_cnt       saturating count of samples discarded in WAIT_SP
//
// Configuration macro:
//   OPERAND_PAIRER_DROP_CNT_EN  defined   -> drop counter implemented
//                               undefined -> drop_cnt tied to 0
module operand_pairer #(
  parameter int NUM_BITS  = 32,
  parameter int DECIM     = 1,
  parameter int DROP_BITS = 8
) (
  input logic             clk,
  input logic             rst,
  operand_pairer_if.slave bus
);

  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);

  typedef enum logic {
    WAIT_SP = 1'b0,
    RUN     = 1'b1
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [NUM_BITS-1:0] sp_reg;
  logic [NUM_BITS-1:0] eff_sp;
  logic [DCNT_W-1:0]   dcnt;
  logic [DCNT_W-1:0]   dcnt_next;
  logic                accept_sp;
  logic                meas_run;
  logic                emit;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_SP;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: sp_clr overrides a simultaneous sp_en.
  always_comb begin
    next_state = state;
    if (bus.sp_clr) begin
      next_state = WAIT_SP;
    end else if (bus.sp_en) begin
      next_state = RUN;
    end
  end

  // Output/datapath decode. A measurement arriving with the accepting sp_en
  // already counts as a RUN sample, using the bypassed sp_in as its setpoint.
  always_comb begin
    accept_sp = bus.sp_en && !bus.sp_clr;
    meas_run  = bus.meas_en && !bus.sp_clr && ((state == RUN) || bus.sp_en);
    emit      = meas_run && (dcnt == DCNT_LAST);
    eff_sp    = bus.sp_en ? bus.sp_in : sp_reg;
    dcnt_next = dcnt;
    if (bus.sp_clr) begin
      dcnt_next = '0;
    end else if (meas_run) begin
      dcnt_next = emit ? '0 : dcnt + DCNT_W'(1);
    end
  end

  // Setpoint hold, decimation counter and registered operand outputs.
  // The operand registers keep the last emitted pair between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_reg             <= '0;
      dcnt               <= '0;
      bus.data_out       <= '0;
      bus.extra_data_out <= '0;
      bus.data_en_out    <= 1'b0;
    end else begin
      if (accept_sp) begin
        sp_reg <= bus.sp_in;
      end
      dcnt            <= dcnt_next;
      bus.data_en_out <= emit;
      if (emit) begin
        bus.data_out       <= eff_sp;
        bus.extra_data_out <= bus.meas_in;
      end
    end
  end

  assign bus.armed = (state == RUN);

`ifdef OPERAND_PAIRER_DROP_CNT_EN
  logic                 drop;
  logic [DROP_BITS-1:0] drop_q;

  assign drop = bus.meas_en && !meas_run;

  // Saturating count of samples discarded while no setpoint is valid
  // (including a sample that coincides with sp_clr).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop && (drop_q != {DROP_BITS{1'b1}})) begin
      drop_q <= drop_q + DROP_BITS'(1);
    end
  end

  assign bus.drop_cnt = drop_q;
`else
  assign bus.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_operand_pairer.sv
// tb_operand_pairer
// Table-driven self-checking bench for operand_pairer. One instance with
// DECIM=1 runs the vector table plus reset and saturation sequences; a second
// instance with DECIM=3 runs the decimation sequence.
module tb_operand_pairer;

`ifdef OPERAND_PAIRER_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  operand_pairer_if #(.NUM_BITS(32), .DROP_BITS(8)) bus1 ();
  operand_pairer_if #(.NUM_BITS(32), .DROP_BITS(8)) bus3 ();

  operand_pairer #(.NUM_BITS(32), .DECIM(1), .DROP_BITS(8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  operand_pairer #(.NUM_BITS(32), .DECIM(3), .DROP_BITS(8)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );

  typedef struct {
    string       name;
    logic        sp_en;
    logic [31:0] sp_in;
    logic        sp_clr;
    logic        meas_en;
    logic [31:0] meas_in;
    logic        exp_en;
    logic [31:0] exp_data;
    logic [31:0] exp_extra;
    logic        exp_armed;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic sp_en, logic [31:0] sp_in,
                              logic sp_clr, logic meas_en, logic [31:0] meas_in,
                              logic exp_en, logic [31:0] exp_data,
                              logic [31:0] exp_extra, logic exp_armed,
                              logic [7:0] exp_drop);
    vec_t v;
    v.name = name;       v.sp_en = sp_en;         v.sp_in = sp_in;
    v.sp_clr = sp_clr;   v.meas_en = meas_en;     v.meas_in = meas_in;
    v.exp_en = exp_en;   v.exp_data = exp_data;   v.exp_extra = exp_extra;
    v.exp_armed = exp_armed;
    v.exp_drop = exp_drop;
    return v;
  endfunction

  function automatic logic [7:0] dexp(logic [7:0] d);
    return DROP_EN ? d : 8'd0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the selected bus (1 or 3), idle the other,
  // then step past the next rising edge.
  task automatic applyStimulus(input int which, input logic sp_en,
                               input logic [31:0] sp_in, input logic sp_clr,
                               input logic meas_en, input logic [31:0] meas_in);
    bus1.sp_en = 1'b0; bus1.sp_in = '0; bus1.sp_clr = 1'b0;
    bus1.meas_en = 1'b0; bus1.meas_in = '0;
    bus3.sp_en = 1'b0; bus3.sp_in = '0; bus3.sp_clr = 1'b0;
    bus3.meas_en = 1'b0; bus3.meas_in = '0;
    if (which == 3) begin
      bus3.sp_en = sp_en; bus3.sp_in = sp_in; bus3.sp_clr = sp_clr;
      bus3.meas_en = meas_en; bus3.meas_in = meas_in;
    end else begin
      bus1.sp_en = sp_en; bus1.sp_in = sp_in; bus1.sp_clr = sp_clr;
      bus1.meas_en = meas_en; bus1.meas_in = meas_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int which, input string name,
                             input logic exp_en, input logic [31:0] exp_data,
                             input logic [31:0] exp_extra, input logic exp_armed,
                             input logic [7:0] exp_drop);
    if (which == 3) begin
      check({name, ".en"},    32'(bus3.data_en_out), 32'(exp_en));
      check({name, ".data"},  bus3.data_out,         exp_data);
      check({name, ".extra"}, bus3.extra_data_out,   exp_extra);
      check({name, ".armed"}, 32'(bus3.armed),       32'(exp_armed));
      check({name, ".drop"},  32'(bus3.drop_cnt),    32'(dexp(exp_drop)));
    end else begin
      check({name, ".en"},    32'(bus1.data_en_out), 32'(exp_en));
      check({name, ".data"},  bus1.data_out,         exp_data);
      check({name, ".extra"}, bus1.extra_data_out,   exp_extra);
      check({name, ".armed"}, 32'(bus1.armed),       32'(exp_armed));
      check({name, ".drop"},  32'(bus1.drop_cnt),    32'(dexp(exp_drop)));
    end
  endtask

  initial begin
    logic [31:0] last_extra;
    logic [31:0] last_data;
    logic        exp_en;
    logic        saw_en;

    // DECIM=1 vector table; expected values are the state after the edge.
    //                name        spe sp_in clr me meas  en  data extra arm drop
    vecs.push_back(mk("drop1",     0, 0,   0, 1, 5,     0, 0,   0,   0, 1));
    vecs.push_back(mk("drop2",     0, 0,   0, 1, 5,     0, 0,   0,   0, 2));
    vecs.push_back(mk("drop3",     0, 0,   0, 1, 5,     0, 0,   0,   0, 3));
    vecs.push_back(mk("sp100",     1, 100, 0, 0, 0,     0, 0,   0,   1, 3));
    vecs.push_back(mk("pair40",    0, 0,   0, 1, 40,    1, 100, 40,  1, 3));
    vecs.push_back(mk("hold",      0, 0,   0, 0, 0,     0, 100, 40,  1, 3));
    vecs.push_back(mk("bypass200", 1, 200, 0, 1, 9,     1, 200, 9,   1, 3));
    vecs.push_back(mk("b2b11",     0, 0,   0, 1, 11,    1, 200, 11,  1, 3));
    vecs.push_back(mk("b2b12",     0, 0,   0, 1, 12,    1, 200, 12,  1, 3));
    vecs.push_back(mk("clr_all",   1, 300, 1, 1, 7,     0, 200, 12,  0, 4));
    vecs.push_back(mk("drop_post", 0, 0,   0, 1, 8,     0, 200, 12,  0, 5));
    vecs.push_back(mk("wait_byp",  1, 50,  0, 1, 3,     1, 50,  3,   1, 5));
    vecs.push_back(mk("clr",       0, 0,   1, 0, 0,     0, 50,  3,   0, 5));
    vecs.push_back(mk("drop6",     0, 0,   0, 1, 1,     0, 50,  3,   0, 6));
    vecs.push_back(mk("sp60",      1, 60,  0, 0, 0,     0, 50,  3,   1, 6));
    vecs.push_back(mk("pair60",    0, 0,   0, 1, 2,     1, 60,  2,   1, 6));

    rst = 1'b1;
    bus1.sp_en = 1'b0; bus1.sp_in = '0; bus1.sp_clr = 1'b0;
    bus1.meas_en = 1'b0; bus1.meas_in = '0;
    bus3.sp_en = 1'b0; bus3.sp_in = '0; bus3.sp_clr = 1'b0;
    bus3.meas_en = 1'b0; bus3.meas_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput(1, "reset", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(1, vecs[i].sp_en, vecs[i].sp_in, vecs[i].sp_clr,
                    vecs[i].meas_en, vecs[i].meas_in);
      checkOutput(1, vecs[i].name, vecs[i].exp_en, vecs[i].exp_data,
                  vecs[i].exp_extra, vecs[i].exp_armed, vecs[i].exp_drop);
    end

    // Decimation by 3: samples 1..7 strobe on 3 and 6; dcnt ends at 1, so
    // sample 9 is the next one emitted.
    applyStimulus(3, 1, 100, 0, 0, 0);
    checkOutput(3, "d3_sp", 0, 0, 0, 1, 0);
    last_data  = 0;
    last_extra = 0;
    for (int v = 1; v <= 9; v++) begin
      exp_en = (v % 3 == 0);
      if (exp_en) begin
        last_data  = 100;
        last_extra = 32'(v);
      end
      applyStimulus(3, 0, 0, 0, 1, 32'(v));
      checkOutput(3, $sformatf("d3_m%0d", v), exp_en, last_data, last_extra, 1, 0);
    end
    // sp_clr zeroes the decimation counter mid-phase.
    applyStimulus(3, 0, 0, 0, 1, 10);
    checkOutput(3, "d3_m10", 0, 100, 9, 1, 0);
    applyStimulus(3, 0, 0, 1, 0, 0);
    checkOutput(3, "d3_clr", 0, 100, 9, 0, 0);
    applyStimulus(3, 1, 70, 0, 0, 0);
    checkOutput(3, "d3_sp70", 0, 100, 9, 1, 0);
    applyStimulus(3, 0, 0, 0, 1, 11);
    checkOutput(3, "d3_m11", 0, 100, 9, 1, 0);
    applyStimulus(3, 0, 0, 0, 1, 12);
    checkOutput(3, "d3_m12", 0, 100, 9, 1, 0);
    applyStimulus(3, 0, 0, 0, 1, 13);
    checkOutput(3, "d3_m13", 1, 70, 13, 1, 0);

    // Asynchronous reset while a strobe is being presented.
    applyStimulus(1, 1, 100, 0, 1, 40);
    checkOutput(1, "pre_rst", 1, 100, 40, 1, 6);
    rst = 1'b1;
    #1;
    checkOutput(1, "async_rst", 0, 0, 0, 0, 0);
    bus1.sp_en = 1'b0; bus1.meas_en = 1'b0;
    #2 rst = 1'b0;

    // After reset: back in WAIT_SP, so samples are dropped until saturation.
    saw_en = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      applyStimulus(1, 0, 0, 0, 1, 5);
      saw_en = saw_en | bus1.data_en_out;
      if (n == 1) checkOutput(1, "rst_drop1", 0, 0, 0, 0, 1);
      if (n == 255) check("drop255", 32'(bus1.drop_cnt), 32'(dexp(8'd255)));
    end
    check("sat_drop", 32'(bus1.drop_cnt), 32'(dexp(8'd255)));
    check("sat_no_en", 32'(saw_en), 32'd0);
    check("sat_armed", 32'(bus1.armed), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
